mdu: RTL



---
 rtl/mdu.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// mdu -- multi-cycle multiply/divide unit with HI/LO result registers.
//
// Accepts one request at a time while idle. mult/multu (and div/divu when
// built) latch their operands, stay busy for a fixed number of cycles and
// then commit HI/LO together with a one-cycle done pulse. mthi/mtlo write
// HI/LO directly on the accepting edge and never raise busy. Requests seen
// while busy are dropped, not queued.
//
// Build option: define MDU_DIV_EN to build the divider (div/divu). When it is
// not defined, MDUOp 3/4 behave as no-ops and DIV_CYCLES is unused.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high reset
//   A      in  32   operand 1 (dividend / multiplicand / mthi-mtlo source)
//   B      in  32   operand 2 (divisor / multiplier)
//   MDUOp  in   3   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 rsvd
//   start  in   1   request strobe, sampled only when idle
//   busy   out  1   computation in flight
//   done   out  1   one-cycle pulse when new HI/LO becomes visible
//   HI     out 32   HI register
//   LO     out 32   LO register
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Latency must fit the 4-bit counter and be at least one cycle.
  if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
    $error("mdu: MULT_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
    $error("mdu: DIV_CYCLES must be in 1..15");
  end

  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  // Products from the latched operands; only sampled on the commit edge.
  logic [63:0] prod_s, prod_u;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});

`ifdef MDU_DIV_EN
  // Signed division via magnitudes: avoids the 0x80000000 / -1 overflow
  // corner (the magnitude 0x80000000 divides cleanly and negates back to
  // itself) and gives truncation toward zero with remainder sign = dividend.
  logic        div_signed, a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, dvsr, uq, ur, quo, rem;
  assign div_signed = (op_q == OP_DIV);
  assign a_neg      = div_signed & a_q[31];
  assign b_neg      = div_signed & b_q[31];
  assign a_mag      = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag      = b_neg ? (~b_q + 32'd1) : b_q;
  assign b_zero     = (b_q == 32'd0);
  assign dvsr       = b_zero ? 32'd1 : b_mag;  // keep the divider defined
  assign uq         = a_mag / dvsr;
  assign ur         = a_mag % dvsr;
  assign quo        = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem        = a_neg ? (~ur + 32'd1) : ur;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (MDUOp)
            OP_MULT, OP_MULTU: begin
              a_d     = A;
              b_d     = B;
              op_d    = MDUOp;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = S_BUSY;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              a_d     = A;
              b_d     = B;
              op_d    = MDUOp;
              cnt_d   = 4'(DIV_CYCLES);
              state_d = S_BUSY;
            end
`endif
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;  // none / reserved (and div/divu when not built)
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              // Divide by zero still runs the full latency but leaves HI/LO.
              if (!b_zero) begin
                lo_d = quo;
                hi_d = rem;
              end
            end
`endif
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
